alu_issue_stage: RTL and testbench

Issue and retire stage wrapped around `alu64bit`. It buffers ALU commands from an upstream producer in a small FIFO and drives the head entry into an internal `alu64bit` instance. It captures each result in an output register with a valid/ready handshake to the downstream consumer. It also keeps fill-level and retired-operation counters for debug.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu64bit.sv | 30 +++
 rtl/alu_issue_stage.sv | 127 ++++++++++++
 tb/tb_alu_issue_stage.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and widths for the issue stage
package alu_pkg;

  localparam int ALU_DW = 64;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    alu_op_t           op;
    logic              cin;
  } alu_cmd_t;

endpackage

// File: rtl/alu64bit.sv
// rtl/alu64bit.sv - combinational 64-bit AND/OR/ADD/SUB unit
module alu64bit
  import alu_pkg::*;
(
  input  logic [ALU_DW-1:0] a,
  input  logic [ALU_DW-1:0] b,
  input  alu_op_t           op,
  input  logic              cin,
  output logic [ALU_DW-1:0] s,
  output logic              cout
);

  logic [ALU_DW:0] sum;

  // Select the operation; logic ops report no carry, SUB adds the inverted operand
  always_comb begin
    sum = '0;
    case (op)
      ALU_AND: sum = {1'b0, a & b};
      ALU_OR:  sum = {1'b0, a | b};
      ALU_ADD: sum = {1'b0, a} + {1'b0, b} + {{ALU_DW{1'b0}}, cin};
      ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + {{ALU_DW{1'b0}}, cin};
      default: sum = '0;
    endcase
  end

  assign s    = sum[ALU_DW-1:0];
  assign cout = sum[ALU_DW];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO feeding alu64bit with a registered result stage
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_DW-1:0]          in_a,
  input  logic [ALU_DW-1:0]          in_b,
  input  logic [1:0]                 in_op,
  input  logic                       in_cin,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ALU_DW-1:0]          out_s,
  output logic                       out_cout,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     level,
  output logic [31:0]                ops_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  alu_cmd_t         cmd_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  alu_cmd_t         in_cmd;
  alu_cmd_t         head_cmd;
  logic [TAG_W-1:0] head_tag;
  logic [ALU_DW-1:0] alu_s;
  logic             alu_cout;
  logic             push;
  logic             pop;
  logic             retire;

  assign in_cmd   = '{a: in_a, b: in_b, op: alu_op_t'(in_op), cin: in_cin};
  assign in_ready = (level != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign pop      = (level != '0) && (!out_valid || out_ready);
  assign retire   = out_valid && out_ready;

  // Head of the FIFO feeds the ALU; an empty FIFO presents all-zero operands
  always_comb begin
    head_cmd = '0;
    head_tag = '0;
    if (level != '0) begin
      head_cmd = cmd_mem[rd_ptr];
      head_tag = tag_mem[rd_ptr];
    end
  end

  alu64bit u_alu (
    .a    (head_cmd.a),
    .b    (head_cmd.b),
    .op   (head_cmd.op),
    .cin  (head_cmd.cin),
    .s    (alu_s),
    .cout (alu_cout)
  );

  // Storage array carries no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      cmd_mem[wr_ptr] <= in_cmd;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO ahead of any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Result register: load on pop, drop valid when the consumer drains it with nothing behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_cout  <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_s     <= alu_s;
      out_cout  <= alu_cout;
      out_tag   <= head_tag;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of results handed to the consumer; survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else if (!flush && retire && (ops_done != 32'hFFFF_FFFF)) begin
      ops_done <= ops_done + 32'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        cin;
    logic [3:0]  tag;
  } cmd_t;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic [3:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic        in_cin = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_s;
  logic        out_cout;
  logic [3:0]  out_tag;
  logic [2:0]  level;
  logic [31:0] ops_done;

  int   tests_run = 0;
  int   tests_failed = 0;
  cmd_t cur;
  cmd_t sent[$];
  res_t got[$];
  logic [31:0] exp_ops = '0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_cout(out_cout), .out_tag(out_tag),
    .level(level), .ops_done(ops_done)
  );

  // Reference ALU: {cout, s} from plain 65-bit arithmetic
  function automatic logic [64:0] ref_alu(input cmd_t c);
    case (c.op)
      2'b00:   return {1'b0, c.a & c.b};
      2'b01:   return {1'b0, c.a | c.b};
      2'b10:   return {1'b0, c.a} + {1'b0, c.b} + 65'(c.cin);
      default: return {1'b0, c.a} + {1'b0, ~c.b} + 65'(c.cin);
    endcase
  endfunction

  function automatic cmd_t rand_cmd(input logic [3:0] tag);
    cmd_t c;
    c.a   = ($urandom_range(0, 4) == 0) ? '1 : {$urandom, $urandom};
    c.b   = ($urandom_range(0, 4) == 0) ? '1 : {$urandom, $urandom};
    c.op  = 2'($urandom_range(0, 3));
    c.cin = 1'($urandom_range(0, 1));
    c.tag = tag;
    return c;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    cur    = c;
    in_a   = c.a;
    in_b   = c.b;
    in_op  = c.op;
    in_cin = c.cin;
    in_tag = c.tag;
  endtask

  // Advance one clock, recording the handshakes that the coming edge performs
  task automatic tick();
    res_t r;
    if (rst_n && !flush && in_valid && in_ready) sent.push_back(cur);
    if (rst_n && !flush && out_valid && out_ready) begin
      r.s = out_s; r.cout = out_cout; r.tag = out_tag;
      got.push_back(r);
      if (exp_ops != 32'hFFFF_FFFF) exp_ops++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (out_valid || level != 0); i++) tick();
  endtask

  task automatic test_reset();
    cmd_t c;
    logic [64:0] e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, level, ops_done, out_s, out_cout, out_tag} !== {1'b1, 1'b0, 3'd0, 32'd0, 64'd0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset_values: ready=%b valid=%b level=%0d ops=%0d s=%h cout=%b tag=%0d, want 1 0 0 0 0 0 0",
               in_ready, out_valid, level, ops_done, out_s, out_cout, out_tag);
    end
    rst_n = 1'b1;
    @(negedge clk);
    sent.delete(); got.delete(); exp_ops = '0;
    c = '{a: '1, b: '1, op: 2'b10, cin: 1'b1, tag: 4'd3};
    drive_cmd(c);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd1) begin
      tests_failed++;
      $display("FAIL add_accept: valid=%b level=%0d, want 0 1", out_valid, level);
    end
    tick();
    e = ref_alu(c);
    tests_run++;
    if (out_valid !== 1'b1 || out_s !== 64'hFFFF_FFFF_FFFF_FFFF || out_cout !== 1'b1 || out_tag !== 4'd3 || e !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL add_result: valid=%b s=%h cout=%b tag=%0d, want 1 ffffffffffffffff 1 3", out_valid, out_s, out_cout, out_tag);
    end
    tick();
    tests_run++;
    if (ops_done !== 32'd1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_retire: ops=%0d valid=%b, want 1 0", ops_done, out_valid);
    end
  endtask

  task automatic test_sub();
    cmd_t c;
    c = '{a: '1, b: '1, op: 2'b11, cin: 1'b1, tag: 4'd7};
    drive_cmd(c);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_s !== 64'd0 || out_cout !== 1'b1 || out_tag !== 4'd7) begin
      tests_failed++;
      $display("FAIL sub_result: valid=%b s=%h cout=%b tag=%0d, want 1 0 1 7", out_valid, out_s, out_cout, out_tag);
    end
    tick();
    tests_run++;
    if (ops_done !== 32'd2) begin
      tests_failed++;
      $display("FAIL sub_retire: ops=%0d want 2", ops_done);
    end
  endtask

  task automatic test_backpressure();
    cmd_t cs[5];
    logic [64:0] e0;
    logic stable;
    sent.delete(); got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cs[i] = rand_cmd(4'(i));
      drive_cmd(cs[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd4 || in_ready !== 1'b0 || sent.size() != 5) begin
      tests_failed++;
      $display("FAIL bp_full: level=%0d ready=%b accepted=%0d, want 4 0 5", level, in_ready, sent.size());
    end
    e0 = ref_alu(cs[0]);
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || out_tag !== 4'd0 || {out_cout, out_s} !== e0) stable = 1'b0;
      tick();
    end
    tests_run++;
    if (!stable) begin
      tests_failed++;
      $display("FAIL bp_hold: valid=%b tag=%0d s=%h, want 1 0 %h", out_valid, out_tag, out_s, e0[63:0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (got.size() != 5 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_count: results=%0d valid=%b, want 5 0", got.size(), out_valid);
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      tests_run++;
      if (got[i].tag !== 4'(i) || {got[i].cout, got[i].s} !== ref_alu(cs[i])) begin
        tests_failed++;
        $display("FAIL bp_order[%0d]: tag=%0d s=%h, want %0d %h", i, got[i].tag, got[i].s, i, ref_alu(cs[i]));
      end
    end
  endtask

  task automatic test_wrap_random();
    int cyc;
    int bad_ready;
    sent.delete(); got.delete();
    cyc = 0;
    bad_ready = 0;
    while ((sent.size() < 20 || got.size() < 20) && cyc < 2000) begin
      in_valid = (sent.size() < 20) && ($urandom_range(0, 3) != 0);
      drive_cmd(rand_cmd(4'(sent.size())));
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready !== (level != 3'd4) || level > 3'd4) bad_ready++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (sent.size() != 20 || got.size() != 20) begin
      tests_failed++;
      $display("FAIL wrap_count: accepted=%0d retired=%0d after %0d cycles, want 20 20", sent.size(), got.size(), cyc);
    end
    tests_run++;
    if (bad_ready != 0) begin
      tests_failed++;
      $display("FAIL wrap_ready: %0d cycles with in_ready/level inconsistent, want 0", bad_ready);
    end
    for (int i = 0; i < 20 && i < got.size() && i < sent.size(); i++) begin
      tests_run++;
      if (got[i].tag !== sent[i].tag || {got[i].cout, got[i].s} !== ref_alu(sent[i])) begin
        tests_failed++;
        $display("FAIL wrap_result[%0d]: tag=%0d cout=%b s=%h, want %0d %h", i, got[i].tag, got[i].cout, got[i].s, sent[i].tag, ref_alu(sent[i]));
      end
    end
    drain();
    tests_run++;
    if (ops_done !== exp_ops) begin
      tests_failed++;
      $display("FAIL wrap_ops: ops=%0d want %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_flush();
    logic [31:0] ops_before;
    cmd_t c;
    int cyc;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(rand_cmd(4'(8 + i)));
      in_valid = 1'b1;
      tick();
    end
    ops_before = exp_ops;
    flush    = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    drive_cmd(rand_cmd(4'd15));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ops_done !== ops_before) begin
      tests_failed++;
      $display("FAIL flush_state: level=%0d valid=%b ready=%b ops=%0d, want 0 0 1 %0d", level, out_valid, in_ready, ops_done, ops_before);
    end
    sent.delete(); got.delete();
    c = rand_cmd(4'd5);
    drive_cmd(c);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (got.size() == 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (got.size() != 1 || got[0].tag !== 4'd5 || {got[0].cout, got[0].s} !== ref_alu(c)) begin
      tests_failed++;
      $display("FAIL flush_after: retired=%0d, want 1 with tag 5 and %h", got.size(), ref_alu(c));
    end
    tests_run++;
    if (ops_done !== ops_before + 32'd1) begin
      tests_failed++;
      $display("FAIL flush_ops: ops=%0d want %0d", ops_done, ops_before + 32'd1);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(rand_cmd(4'(i)));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, out_valid, level, ops_done, out_s, out_cout, out_tag} !== {1'b1, 1'b0, 3'd0, 32'd0, 64'd0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: ready=%b valid=%b level=%0d ops=%0d s=%h cout=%b tag=%0d, want 1 0 0 0 0 0 0",
               in_ready, out_valid, level, ops_done, out_s, out_cout, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sent.delete(); got.delete(); exp_ops = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sub();
    test_backpressure();
    test_wrap_random();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
